writeback_tracker: RTL and testbench
====================================

Name: writeback_tracker

Overview:
- Producer side of the EX-stage operand bypass interface.
- Owns the EX/MEM and MEM/WB destination/result registers and drives the write-register, reg-write and data signals that the bypass selector consumes.
- Also raises load-use stall to ID/EX, handles multi-cycle data-memory loads via a ready handshake, and counts stall cycles.
- Sits between the ALU output and the register-file write port.

Parameters:
- DATA_W, 32, datapath width of ALU result and load data.
- CNT_W, 16, width of the stall-cycle counter (saturating).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_write_reg  in  5  EX destination register.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_alu_result  in  DATA_W  ALU result / load address.
- ex_flush  in  1  kill the EX instruction; it does not enter EX/MEM.
- id_rs, id_rt  in  5 each  ID-stage source registers.
- mem_ready  in  1  data memory returns load data this cycle.
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1.
- ex_mem_write_reg, mem_wb_write_reg  out  5 each  destination registers of the MEM and WB stages.
- ex_mem_reg_write, mem_wb_reg_write  out  1 each  qualified write enables; 0 for bubbles.
- ex_mem_alu_result  out  DATA_W  MEM-stage bypass data.
- mem_wb_data  out  DATA_W  WB data: load data or ALU result.
- load_use_stall  out  1  combinational; hold PC/IF/ID and inject a bubble into ID/EX.
- pipe_hold  out  1  combinational; freeze all stages, load waiting on memory.
- stall_count  out  CNT_W  total cycles with load_use_stall or pipe_hold asserted.

Behaviour:
- Reset: all outputs and registers go to 0, including stall_count; FSM goes to RUN.
- Reset overrides everything, including a pending WAIT; any outstanding load is discarded.
- Effective write enable: ex_valid & ex_reg_write & ~ex_flush. Writes to register 0 are passed through with the enable as computed; the consumer ignores r0.
- FSM states:
  - RUN: normal flow.
  - WAIT: load in MEM waiting on memory.
- Transitions:
  - RUN->WAIT when the EX/MEM stage holds a load (mem_read latched with enable) and mem_ready=0.
  - WAIT->RUN on the cycle mem_ready=1.
  - If mem_ready=1 in the first MEM cycle, the FSM stays in RUN with no hold.
- pipe_hold:
  - asserted when (state=WAIT, or RUN with a MEM-stage load) and mem_ready=0.
  - While asserted, EX/MEM and MEM/WB hold their values; ex_flush and EX inputs are ignored.
- MEM/WB on a hold-release cycle: latches mem_rdata for loads, ex_mem_alu_result otherwise.
- Normal advance: EX/MEM <- EX inputs (enable qualified as above); MEM/WB <- EX/MEM contents and data. Latency is 1 cycle per stage.
- load_use_stall:
  - condition: ex_valid & ex_mem_read & ex_reg_write & ~ex_flush & ex_write_reg!=0 & (ex_write_reg==id_rs | ex_write_reg==id_rt).
  - forced to 0 while pipe_hold=1.
  - does not alter this block's registers; the EX load still advances.
- stall_count increments by 1 on each cycle with load_use_stall|pipe_hold, and saturates at all-ones.
- Simultaneous ex_flush and load_use_stall: flush wins, no stall.

Test Plan:
- ALU chain: ex_write_reg=5, reg_write=1, result=0x1234 -> next cycle ex_mem_write_reg=5, reg_write=1, ex_mem_alu_result=0x1234; the cycle after, mem_wb_write_reg=5, mem_wb_data=0x1234.
- Load-use: EX load with rt=8, id_rs=8 -> load_use_stall=1 that cycle, 0 the next; stall_count 0->1.
- Slow load: load reaches MEM with mem_ready=0 for 3 cycles, then 1 with mem_rdata=0xCAFE -> pipe_hold=1 for 3 cycles, registers frozen, then mem_wb_data=0xCAFE and stall_count=3.
- Flush: ex_flush=1 with reg_write=1, write_reg=9 -> ex_mem_reg_write=0 next cycle; a simultaneous load-use match gives no stall.
- Reset in WAIT: rst=1 during pipe_hold -> next cycle all outputs 0, FSM in RUN, pipe_hold=0.
- Saturation: CNT_W=4, 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/writeback_tracker.sv
// writeback_tracker
// Producer side of the EX-stage operand bypass. Owns the EX/MEM and MEM/WB
// destination/result registers that the bypass selector reads. It raises the
// load-use stall toward ID/EX, freezes the pipe while a load waits on data
// memory, and counts stall cycles.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ex_*                EX-stage instruction (valid, dest, write-enable, load, result, flush)
//   id_rs, id_rt        ID-stage source registers, used for load-use detection
//   mem_ready/mem_rdata data-memory load return handshake
//   ex_mem_* / mem_wb_* MEM- and WB-stage destination, write-enable and data
//   load_use_stall      comb: hold PC/IF/ID and inject a bubble into ID/EX
//   pipe_hold           comb: freeze every stage while a load waits on memory
//   stall_count         saturating count of cycles with either stall asserted
module writeback_tracker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_flush,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        ex_mem_write_reg,
    output logic [4:0]        mem_wb_write_reg,
    output logic              ex_mem_reg_write,
    output logic              mem_wb_reg_write,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] mem_wb_data,
    output logic              load_use_stall,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic ex_wen;
    logic ex_load;
    logic ex_mem_load;   // EX/MEM holds a live load
    logic lu_hit;

    // A flushed or invalid instruction enters EX/MEM as a bubble.
    assign ex_wen  = ex_valid & ex_reg_write & ~ex_flush;
    assign ex_load = ex_valid & ex_mem_read & ~ex_flush;

    // Load-use hazard: the EX load's destination is needed by the ID instruction.
    // r0 never carries a dependency.
    assign lu_hit = ex_valid & ex_mem_read & ex_reg_write & ~ex_flush
                  & (ex_write_reg != 5'd0)
                  & ((ex_write_reg == id_rs) | (ex_write_reg == id_rt));

    // A full-pipe freeze supersedes the load-use bubble.
    assign load_use_stall = lu_hit & ~pipe_hold;

    always_comb begin
        state_nxt = state;
        pipe_hold = 1'b0;
        case (state)
            RUN: begin
                // A load whose data arrives in its first MEM cycle causes no hold.
                if (ex_mem_load && !mem_ready) begin
                    pipe_hold = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) state_nxt = RUN;
                else           pipe_hold = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Pipeline registers: frozen while pipe_hold, otherwise advance one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_write_reg  <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_load       <= 1'b0;
            ex_mem_alu_result <= '0;
            mem_wb_write_reg  <= '0;
            mem_wb_reg_write  <= 1'b0;
            mem_wb_data       <= '0;
        end else if (!pipe_hold) begin
            ex_mem_write_reg  <= ex_write_reg;
            ex_mem_reg_write  <= ex_wen;
            ex_mem_load       <= ex_load;
            ex_mem_alu_result <= ex_alu_result;
            mem_wb_write_reg  <= ex_mem_write_reg;
            mem_wb_reg_write  <= ex_mem_reg_write;
            mem_wb_data       <= ex_mem_load ? mem_rdata : ex_mem_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if ((load_use_stall || pipe_hold) && !(&stall_count))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_writeback_tracker.sv
// Directed bench for writeback_tracker. A second instance with a 4-bit
// counter shares the inputs and is used for the saturation check.
module tb_writeback_tracker;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [31:0] ex_alu_result;
    logic        ex_flush;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [4:0]  ex_mem_write_reg, mem_wb_write_reg;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [31:0] ex_mem_alu_result, mem_wb_data;
    logic        load_use_stall, pipe_hold;
    logic [15:0] stall_count;

    logic [4:0]  s_ex_mem_write_reg, s_mem_wb_write_reg;
    logic        s_ex_mem_reg_write, s_mem_wb_reg_write;
    logic [31:0] s_ex_mem_alu_result, s_mem_wb_data;
    logic        s_load_use_stall, s_pipe_hold;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    writeback_tracker #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_alu_result(ex_alu_result), .ex_flush(ex_flush), .id_rs(id_rs), .id_rt(id_rt),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ex_mem_write_reg(ex_mem_write_reg), .mem_wb_write_reg(mem_wb_write_reg),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
        .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_data(mem_wb_data),
        .load_use_stall(load_use_stall), .pipe_hold(pipe_hold), .stall_count(stall_count)
    );

    writeback_tracker #(.DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_alu_result(ex_alu_result), .ex_flush(ex_flush), .id_rs(id_rs), .id_rt(id_rt),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ex_mem_write_reg(s_ex_mem_write_reg), .mem_wb_write_reg(s_mem_wb_write_reg),
        .ex_mem_reg_write(s_ex_mem_reg_write), .mem_wb_reg_write(s_mem_wb_reg_write),
        .ex_mem_alu_result(s_ex_mem_alu_result), .mem_wb_data(s_mem_wb_data),
        .load_use_stall(s_load_use_stall), .pipe_hold(s_pipe_hold), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_write_reg = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_alu_result = 0; ex_flush = 0; id_rs = 0; id_rt = 0;
        mem_ready = 1; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic drive_ex(input logic [4:0] wr, input logic rw, input logic ld,
                            input logic [31:0] res);
        ex_valid = 1; ex_write_reg = wr; ex_reg_write = rw; ex_mem_read = ld;
        ex_alu_result = res;
    endtask

    task automatic test_reset();
        ex_valid = 1; ex_write_reg = 7; ex_reg_write = 1; ex_alu_result = 32'h55;
        tick();
        do_reset();
        checks++;
        if ({ex_mem_write_reg, mem_wb_write_reg, ex_mem_reg_write, mem_wb_reg_write} !== 12'h0) begin
            errors++; $display("FAIL reset_regs got %h %h %b %b exp 0", ex_mem_write_reg,
                               mem_wb_write_reg, ex_mem_reg_write, mem_wb_reg_write);
        end
        checks++;
        if (ex_mem_alu_result !== 32'h0 || mem_wb_data !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h %h exp 0", ex_mem_alu_result, mem_wb_data);
        end
        checks++;
        if (stall_count !== 16'd0 || pipe_hold !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got cnt=%0d hold=%b lu=%b exp 0", stall_count,
                               pipe_hold, load_use_stall);
        end
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive_ex(5'd5, 1'b1, 1'b0, 32'h1234);
        tick();
        drive_ex(5'd6, 1'b1, 1'b0, 32'hBEEF);   // back-to-back ALU op
        checks++;
        if (ex_mem_write_reg !== 5'd5 || ex_mem_reg_write !== 1'b1 || ex_mem_alu_result !== 32'h1234) begin
            errors++; $display("FAIL alu_exmem got %0d %b %h exp 5 1 1234", ex_mem_write_reg,
                               ex_mem_reg_write, ex_mem_alu_result);
        end
        tick();
        idle();
        checks++;
        if (mem_wb_write_reg !== 5'd5 || mem_wb_reg_write !== 1'b1 || mem_wb_data !== 32'h1234) begin
            errors++; $display("FAIL alu_memwb got %0d %b %h exp 5 1 1234", mem_wb_write_reg,
                               mem_wb_reg_write, mem_wb_data);
        end
        checks++;
        if (ex_mem_write_reg !== 5'd6 || ex_mem_alu_result !== 32'hBEEF) begin
            errors++; $display("FAIL b2b_exmem got %0d %h exp 6 beef", ex_mem_write_reg, ex_mem_alu_result);
        end
        tick();
        checks++;
        if (mem_wb_data !== 32'hBEEF || ex_mem_reg_write !== 1'b0) begin
            errors++; $display("FAIL b2b_memwb got %h %b exp beef 0", mem_wb_data, ex_mem_reg_write);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_ex(5'd8, 1'b1, 1'b1, 32'h40);
        id_rs = 8; id_rt = 2;
        #1;
        checks++;
        if (load_use_stall !== 1'b1 || stall_count !== 16'd0) begin
            errors++; $display("FAIL lu_assert got lu=%b cnt=%0d exp 1 0", load_use_stall, stall_count);
        end
        tick();
        idle();   // bubble injected into ID/EX; the load now sits in MEM with data ready
        mem_rdata = 32'h77;
        #1;
        checks++;
        if (load_use_stall !== 1'b0 || pipe_hold !== 1'b0 || stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_release got lu=%b hold=%b cnt=%0d exp 0 0 1", load_use_stall,
                               pipe_hold, stall_count);
        end
        tick();
        checks++;
        if (mem_wb_data !== 32'h77 || mem_wb_write_reg !== 5'd8) begin
            errors++; $display("FAIL lu_wb got %h %0d exp 77 8", mem_wb_data, mem_wb_write_reg);
        end
        // rt match also stalls
        drive_ex(5'd12, 1'b1, 1'b1, 32'h0);
        id_rs = 3; id_rt = 12;
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++; $display("FAIL lu_rt got %b exp 1", load_use_stall);
        end
        // r0 destination never stalls
        ex_write_reg = 0; id_rs = 0; id_rt = 0;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++; $display("FAIL lu_r0 got %b exp 0", load_use_stall);
        end
        idle();
    endtask

    task automatic test_slow_load();
        do_reset();
        drive_ex(5'd10, 1'b1, 1'b1, 32'h100);
        tick();
        // Next EX op is a load hitting ID's rs; stall must be masked by the hold.
        drive_ex(5'd3, 1'b1, 1'b1, 32'h33);
        id_rs = 3;
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pipe_hold !== 1'b1 || load_use_stall !== 1'b0) begin
                errors++; $display("FAIL slow_hold[%0d] got hold=%b lu=%b exp 1 0", i, pipe_hold,
                                   load_use_stall);
            end
            tick();
            checks++;
            if (ex_mem_write_reg !== 5'd10 || ex_mem_alu_result !== 32'h100 ||
                mem_wb_reg_write !== 1'b0 || stall_count !== 16'(i + 1)) begin
                errors++; $display("FAIL slow_frozen[%0d] got %0d %h %b cnt=%0d exp 10 100 0 %0d", i,
                                   ex_mem_write_reg, ex_mem_alu_result, mem_wb_reg_write,
                                   stall_count, i + 1);
            end
        end
        mem_ready = 1; mem_rdata = 32'hCAFE; id_rs = 0;
        #1;
        checks++;
        if (pipe_hold !== 1'b0) begin
            errors++; $display("FAIL slow_release got hold=%b exp 0", pipe_hold);
        end
        tick();
        idle();
        checks++;
        if (mem_wb_data !== 32'hCAFE || mem_wb_write_reg !== 5'd10 || mem_wb_reg_write !== 1'b1 ||
            stall_count !== 16'd3 || ex_mem_write_reg !== 5'd3) begin
            errors++; $display("FAIL slow_wb got %h %0d %b cnt=%0d exmem=%0d exp cafe 10 1 3 3",
                               mem_wb_data, mem_wb_write_reg, mem_wb_reg_write, stall_count,
                               ex_mem_write_reg);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_ex(5'd9, 1'b1, 1'b1, 32'h99);
        ex_flush = 1; id_rs = 9;
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++; $display("FAIL flush_lu got %b exp 0", load_use_stall);
        end
        tick();
        idle();
        mem_ready = 0;   // flushed load must not be treated as a MEM load
        #1;
        checks++;
        if (ex_mem_reg_write !== 1'b0 || pipe_hold !== 1'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL flush_exmem got wen=%b hold=%b cnt=%0d exp 0 0 0",
                               ex_mem_reg_write, pipe_hold, stall_count);
        end
        idle();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive_ex(5'd4, 1'b1, 1'b1, 32'h44);
        tick();
        idle();
        mem_ready = 0;
        tick();
        #1;
        checks++;
        if (pipe_hold !== 1'b1 || stall_count !== 16'd1) begin
            errors++; $display("FAIL wait_entry got hold=%b cnt=%0d exp 1 1", pipe_hold, stall_count);
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (pipe_hold !== 1'b0 || stall_count !== 16'd0 || ex_mem_write_reg !== 5'd0 ||
            ex_mem_reg_write !== 1'b0 || mem_wb_data !== 32'h0 || ex_mem_alu_result !== 32'h0) begin
            errors++; $display("FAIL wait_reset got hold=%b cnt=%0d %0d %b %h %h exp all 0", pipe_hold,
                               stall_count, ex_mem_write_reg, ex_mem_reg_write, mem_wb_data,
                               ex_mem_alu_result);
        end
        tick();   // still memory-not-ready: RUN with no MEM load must not hold
        checks++;
        if (pipe_hold !== 1'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL wait_run got hold=%b cnt=%0d exp 0 0", pipe_hold, stall_count);
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_ex(5'd8, 1'b1, 1'b1, 32'h0);
        id_rs = 8;
        mem_ready = 1;
        for (int i = 0; i < 20; i++) tick();
        idle();
        #1;
        checks++;
        if (s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_cnt4 got %0d exp 15", s_stall_count);
        end
        checks++;
        if (stall_count !== 16'd20) begin
            errors++; $display("FAIL sat_cnt16 got %0d exp 20", stall_count);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_slow_load();
        test_flush();
        test_reset_in_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
